// File: rtl/biriscv_mul_arbiter_pkg.sv
// Shared definitions for the multiplier arbiter: FSM state encoding and pipe ids.
package biriscv_mul_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_BUSY  = 2'd1,
    ARB_DRAIN = 2'd2
  } arb_state_t;

  localparam logic PIPE0 = 1'b0;
  localparam logic PIPE1 = 1'b1;

endpackage

// File: rtl/biriscv_rr_arb2.sv
// Two-requester round-robin arbiter; the pointer moves to the non-granted side on every grant.
module biriscv_rr_arb2
  import biriscv_mul_arbiter_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] grant_o
);

  logic ptr_q;

  always_comb begin
    grant_o = 2'b00;
    if (en_i) begin
      if (&req_i) grant_o[ptr_q] = 1'b1;
      else        grant_o = req_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)         ptr_q <= PIPE0;
    else if (|grant_o) ptr_q <= grant_o[PIPE0] ? PIPE1 : PIPE0;
  end

endmodule

// File: rtl/biriscv_mul_arbiter.sv
// Shares one iterative multiplier between both issue pipes and routes its result back to the owner.
module biriscv_mul_arbiter
  import biriscv_mul_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        pipe0_valid_i,
  input  logic [31:0] pipe0_ra_i,
  input  logic [31:0] pipe0_rb_i,
  input  logic [4:0]  pipe0_rd_idx_i,
  output logic        pipe0_accept_o,
  input  logic        pipe0_flush_i,
  input  logic        pipe1_valid_i,
  input  logic [31:0] pipe1_ra_i,
  input  logic [31:0] pipe1_rb_i,
  input  logic [4:0]  pipe1_rd_idx_i,
  output logic        pipe1_accept_o,
  input  logic        pipe1_flush_i,
  output logic        mul_valid_o,
  output logic [31:0] mul_ra_o,
  output logic [31:0] mul_rb_o,
  output logic [4:0]  mul_rd_idx_o,
  input  logic        mul_wb_valid_i,
  input  logic [31:0] mul_wb_value_i,
  output logic        pipe0_wb_valid_o,
  output logic        pipe1_wb_valid_o,
  output logic [31:0] wb_value_o,
  output logic [4:0]  wb_rd_idx_o,
  output logic        busy_o,
  output logic        timeout_o
);

  arb_state_t       state_q;
  logic             owner_q;
  logic             kill_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             mul_valid_q;
  logic [31:0]      mul_ra_q;
  logic [31:0]      mul_rb_q;
  logic [4:0]       mul_rd_q;
  logic             wb0_q;
  logic             wb1_q;
  logic [31:0]      wb_value_q;
  logic [4:0]       wb_rd_q;
  logic             timeout_q;
  logic [1:0]       grant;
  logic             owner_flush;

  // A pipe flushing in the same cycle it requests is not eligible for a grant.
  biriscv_rr_arb2 u_rr (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (state_q == ARB_IDLE),
    .req_i  ({pipe1_valid_i & ~pipe1_flush_i, pipe0_valid_i & ~pipe0_flush_i}),
    .grant_o(grant)
  );

  assign owner_flush = (owner_q == PIPE1) ? pipe1_flush_i : pipe0_flush_i;
  assign cnt_d       = cnt_q + 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ARB_IDLE;
      owner_q     <= PIPE0;
      kill_q      <= 1'b0;
      cnt_q       <= '0;
      mul_valid_q <= 1'b0;
      mul_ra_q    <= '0;
      mul_rb_q    <= '0;
      mul_rd_q    <= '0;
      wb0_q       <= 1'b0;
      wb1_q       <= 1'b0;
      wb_value_q  <= '0;
      wb_rd_q     <= '0;
      timeout_q   <= 1'b0;
    end else begin
      mul_valid_q <= 1'b0;
      wb0_q       <= 1'b0;
      wb1_q       <= 1'b0;
      case (state_q)
        ARB_IDLE: begin
          if (|grant) begin
            state_q     <= ARB_BUSY;
            mul_valid_q <= 1'b1;
            owner_q     <= grant[PIPE1];
            kill_q      <= 1'b0;
            cnt_q       <= '0;
            mul_ra_q    <= grant[PIPE1] ? pipe1_ra_i     : pipe0_ra_i;
            mul_rb_q    <= grant[PIPE1] ? pipe1_rb_i     : pipe0_rb_i;
            mul_rd_q    <= grant[PIPE1] ? pipe1_rd_idx_i : pipe0_rd_idx_i;
          end
        end
        ARB_BUSY, ARB_DRAIN: begin
          // A result always frees the unit; it is delivered only if the owner is still live.
          if (mul_wb_valid_i) begin
            state_q <= ARB_IDLE;
            if (!kill_q && !owner_flush) begin
              wb_value_q <= mul_wb_value_i;
              wb_rd_q    <= mul_rd_q;
              wb0_q      <= (owner_q == PIPE0);
              wb1_q      <= (owner_q == PIPE1);
            end
          end else if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
            state_q   <= ARB_IDLE;
            timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
            if (owner_flush) begin
              kill_q  <= 1'b1;
              state_q <= ARB_DRAIN;
            end
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign pipe0_accept_o   = grant[PIPE0];
  assign pipe1_accept_o   = grant[PIPE1];
  assign mul_valid_o      = mul_valid_q;
  assign mul_ra_o         = mul_ra_q;
  assign mul_rb_o         = mul_rb_q;
  assign mul_rd_idx_o     = mul_rd_q;
  assign pipe0_wb_valid_o = wb0_q;
  assign pipe1_wb_valid_o = wb1_q;
  assign wb_value_o       = wb_value_q;
  assign wb_rd_idx_o      = wb_rd_q;
  assign busy_o           = (state_q != ARB_IDLE);
  assign timeout_o        = timeout_q;

endmodule

// File: tb/tb_biriscv_mul_arbiter.sv
// Randomized bench for biriscv_mul_arbiter with a transaction-level model and directed literal checks.
module tb_biriscv_mul_arbiter;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        p0v, p1v, p0f, p1f;
  logic [31:0] p0ra, p0rb, p1ra, p1rb;
  logic [4:0]  p0rd, p1rd;
  logic        acc0, acc1;
  logic        mv;
  logic [31:0] mra, mrb;
  logic [4:0]  mrd;
  logic        wbi;
  logic [31:0] wbv;
  logic        wb0, wb1;
  logic [31:0] wb_val;
  logic [4:0]  wb_rd;
  logic        busy, tmo;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  always #5 clk = ~clk;

  biriscv_mul_arbiter #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(8)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .pipe0_valid_i(p0v), .pipe0_ra_i(p0ra), .pipe0_rb_i(p0rb), .pipe0_rd_idx_i(p0rd),
    .pipe0_accept_o(acc0), .pipe0_flush_i(p0f),
    .pipe1_valid_i(p1v), .pipe1_ra_i(p1ra), .pipe1_rb_i(p1rb), .pipe1_rd_idx_i(p1rd),
    .pipe1_accept_o(acc1), .pipe1_flush_i(p1f),
    .mul_valid_o(mv), .mul_ra_o(mra), .mul_rb_o(mrb), .mul_rd_idx_o(mrd),
    .mul_wb_valid_i(wbi), .mul_wb_value_i(wbv),
    .pipe0_wb_valid_o(wb0), .pipe1_wb_valid_o(wb1),
    .wb_value_o(wb_val), .wb_rd_idx_o(wb_rd),
    .busy_o(busy), .timeout_o(tmo)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: the unit either holds one op (owner, age, killed) or is free.
  bit          m_busy, m_killed, m_timeout;
  int          m_owner, m_age, m_next;
  bit          e_mv, e_wb0, e_wb1;
  logic [31:0] e_ra, e_rb, e_wbv;
  logic [4:0]  e_rd, e_wbrd;

  function automatic int pick();
    bit r0, r1;
    r0 = p0v && !p0f;
    r1 = p1v && !p1f;
    if (m_busy) return -1;
    if (r0 && r1) return m_next;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  always @(posedge clk) begin
    int g;
    bit fl;
    g = pick();
    if (rst_i) begin
      m_busy = 0; m_killed = 0; m_timeout = 0; m_owner = 0; m_age = 0; m_next = 0;
      e_mv = 0; e_wb0 = 0; e_wb1 = 0;
      e_ra = '0; e_rb = '0; e_rd = '0; e_wbv = '0; e_wbrd = '0;
    end else begin
      e_mv = 0; e_wb0 = 0; e_wb1 = 0;
      if (g >= 0) begin
        e_mv = 1;
        e_ra = (g == 1) ? p1ra : p0ra;
        e_rb = (g == 1) ? p1rb : p0rb;
        e_rd = (g == 1) ? p1rd : p0rd;
        m_busy = 1; m_owner = g; m_killed = 0; m_age = 0; m_next = 1 - g;
      end else if (m_busy) begin
        m_age++;
        fl = (m_owner == 1) ? p1f : p0f;
        if (wbi) begin
          if (!m_killed && !fl) begin
            e_wb0 = (m_owner == 0); e_wb1 = (m_owner == 1);
            e_wbv = wbv; e_wbrd = e_rd;
          end
          m_busy = 0;
        end else if (m_age >= TIMEOUT) begin
          m_timeout = 1; m_busy = 0;
        end else if (fl) begin
          m_killed = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    int g;
    if (chk_en) begin
      g = pick();
      chk("accept0", acc0, (g == 0));
      chk("accept1", acc1, (g == 1));
      chk("mul_valid", mv, e_mv);
      chk("busy", busy, m_busy);
      chk("timeout", tmo, m_timeout);
      chk("wb0", wb0, e_wb0);
      chk("wb1", wb1, e_wb1);
      if (e_mv) begin
        chk("mul_ra", mra, e_ra);
        chk("mul_rb", mrb, e_rb);
        chk("mul_rd", mrd, e_rd);
      end
      if (e_wb0 || e_wb1) begin
        chk("wb_value", wb_val, e_wbv);
        chk("wb_rd", wb_rd, e_wbrd);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  initial begin
    int rem;
    bit a0, a1, mvs;
    rst_i = 1'b1;
    p0v = 0; p1v = 0; p0f = 0; p1f = 0;
    p0ra = '0; p0rb = '0; p1ra = '0; p1rb = '0; p0rd = '0; p1rd = '0;
    wbi = 0; wbv = '0;
    @(posedge clk); #1;
    do_reset();
    chk_en = 1;

    // Reset state
    @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst timeout", tmo, 0);
    chk("rst mul_ra", mra, 0);
    chk("rst wb_value", wb_val, 0);

    // Single request from pipe 0
    tick();
    p0v = 1; p0ra = 32'h0001_2345; p0rb = 32'h0000_0010; p0rd = 5'd7;
    @(negedge clk);
    chk("single accept0", acc0, 1);
    tick(); p0v = 0;
    @(negedge clk);
    chk("single mul_valid", mv, 1);
    chk("single mul_ra", mra, 32'h0001_2345);
    chk("single mul_rd", mrd, 5'd7);
    tick(); wbi = 1; wbv = 32'h0012_3450;
    tick(); wbi = 0;
    @(negedge clk);
    chk("single wb0", wb0, 1);
    chk("single wb1", wb1, 0);
    chk("single wb_value", wb_val, 32'h0012_3450);
    chk("single wb_rd", wb_rd, 5'd7);

    // Simultaneous requests from reset alternate
    tick(); do_reset();
    p0v = 1; p1v = 1; p0ra = 32'd3; p0rb = 32'd4; p1ra = 32'd5; p1rb = 32'd6; p1rd = 5'd9;
    @(negedge clk);
    chk("both first acc0", acc0, 1);
    chk("both first acc1", acc1, 0);
    tick(); p0v = 0;
    tick(); wbi = 1; wbv = 32'd12;
    tick(); wbi = 0;
    @(negedge clk);
    chk("both second acc1", acc1, 1);
    tick(); p1v = 0;
    tick(); wbi = 1; wbv = 32'd30;
    tick(); wbi = 0; p0v = 1; p1v = 1;
    @(negedge clk);
    chk("both third acc0", acc0, 1);
    tick(); p0v = 0; p1v = 0;
    tick(); wbi = 1;
    tick(); wbi = 0;

    // Owner flush: pipe 1 launched, flushed, result dropped
    p1v = 1;
    @(negedge clk);
    chk("flush acc1", acc1, 1);
    tick(); p1v = 0;
    tick();
    tick(); p1f = 1; p0v = 1;
    tick(); p1f = 0;
    tick(); wbi = 1;
    tick(); wbi = 0;
    @(negedge clk);
    chk("flush wb1", wb1, 0);
    chk("flush busy", busy, 0);
    chk("flush next acc0", acc0, 1);
    tick(); p0v = 0;
    tick(); p1f = 1;
    tick(); p1f = 0; wbi = 1; wbv = 32'hCAFE_0001;
    tick(); wbi = 0;
    @(negedge clk);
    chk("nonowner wb0", wb0, 1);

    // Timeout: launch and never answer
    tick(); p0v = 1;
    tick(); p0v = 0;
    repeat (14) tick();
    @(negedge clk);
    chk("tmo busy before", busy, 1);
    chk("tmo flag before", tmo, 0);
    tick();
    @(negedge clk);
    chk("tmo flag", tmo, 1);
    chk("tmo busy after", busy, 0);
    tick(); p1v = 1;
    tick(); p1v = 0;
    tick(); wbi = 1;
    tick(); wbi = 0;
    @(negedge clk);
    chk("tmo served wb1", wb1, 1);
    chk("tmo sticky", tmo, 1);

    // Reset in the middle of an op
    tick(); p0v = 1;
    tick(); p0v = 0;
    tick(); rst_i = 1;
    tick(); rst_i = 0;
    @(negedge clk);
    chk("rstbusy busy", busy, 0);
    chk("rstbusy timeout", tmo, 0);
    tick(); wbi = 1;
    tick(); wbi = 0;
    @(negedge clk);
    chk("rstbusy wb0", wb0, 0);

    // Randomized traffic
    rem = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      a0 = acc0; a1 = acc1; mvs = mv;
      tick();
      if (a0 || (!p0v && $urandom_range(0, 2) == 0)) begin
        p0v = (cyc < 3950) && ($urandom_range(0, 1) == 1);
        p0ra = $urandom; p0rb = $urandom; p0rd = 5'($urandom);
      end
      if (a1 || (!p1v && $urandom_range(0, 2) == 0)) begin
        p1v = (cyc < 3950) && ($urandom_range(0, 1) == 1);
        p1ra = $urandom; p1rb = $urandom; p1rd = 5'($urandom);
      end
      p0f = ($urandom_range(0, 11) == 0);
      p1f = ($urandom_range(0, 11) == 0);
      wbi = 0;
      if (mvs) rem = ($urandom_range(0, 40) == 0) ? 0 : $urandom_range(1, 14);
      if (rem > 0) begin
        rem--;
        if (rem == 0) begin
          wbi = 1;
          wbv = $urandom;
        end
      end
    end
    p0v = 0; p1v = 0; p0f = 0; p1f = 0; wbi = 0;
    repeat (20) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
